pin_debounce: RTL and testbench
===============================

// Module: pin_debounce
// PURPOSE
//   Input-side companion to the pin-driving blinker logic. Samples one asynchronous board pin,
//   synchronises and debounces it, then emits a clean level, one-cycle edge pulses and a press counter.
//   Sits between a top-level inout/input pin and user logic clocked by the OSCH-derived clock.
// PARAMETERS
//   DEBOUNCE_CYCLES  16630  cycles the synced input must hold a new value before acceptance (>=2; ~1 ms @16.63 MHz)
//   ACTIVE_LOW       0      1: a press is level 1->0; 0: a press is level 0->1
//   RESET_LEVEL      0      value loaded into the sync flops and into level on reset
//   CNT_W            8      width of press_count
//   LONG_CYCLES      16630000  debounced active-hold cycles for long_press (used only with LONG_PRESS_EN)
// PORTS
//   clk          in   1      single clock, all logic on posedge
//   rst          in   1      synchronous, active-high reset
//   pin_in       in   1      raw asynchronous pin value
//   count_clr    in   1      synchronous clear of press_count
//   level        out  1      debounced pin value
//   rise_pulse   out  1      one-cycle pulse when level goes 0->1
//   fall_pulse   out  1      one-cycle pulse when level goes 1->0
//   press_count  out  CNT_W  number of presses, wraps modulo 2^CNT_W
//   long_press   out  1      one-cycle pulse per press that is held LONG_CYCLES (0 without LONG_PRESS_EN)
// BEHAVIOUR
//   - Reset: sync0=sync1=level=RESET_LEVEL; state=STABLE; timer=0; rise/fall/long_press=0; press_count=0.
//   - Sync: 2-flop chain sync0<=pin_in, sync1<=sync0. Only sync1 feeds the FSM.
//   - FSM STABLE: if sync1!=level -> SETTLING, timer<=0. Else stay.
//   - FSM SETTLING: if sync1==level -> STABLE (bounce rejected, no pulse, level unchanged).
//     Elif timer==DEBOUNCE_CYCLES-1 -> level<=sync1, matching edge pulse high next cycle, -> STABLE.
//     Else timer<=timer+1.
//   - Timer width $clog2(DEBOUNCE_CYCLES); never exceeds DEBOUNCE_CYCLES-1.
//   - Latency: a clean pin change is reflected on level at the (DEBOUNCE_CYCLES+3)th posedge, counting
//     the first posedge that samples the new pin value as 1. Edge pulse is asserted in the same cycle
//     that level changes.
//   - Any glitch shorter than DEBOUNCE_CYCLES synced cycles produces no level change and no pulse.
//     Every bounce restarts the timer from 0.
//   - Press: rise_pulse (ACTIVE_LOW=0) or fall_pulse (ACTIVE_LOW=1). press_count increments by 1 on a press.
//     It wraps from 2^CNT_W-1 to 0.
//   - count_clr: press_count<=0. With a simultaneous press, press_count<=1.
//   - rise_pulse and fall_pulse are never high together. Each is high for exactly 1 cycle per accepted edge.
//   - Reset mid-SETTLING discards the pending change. No pulse is emitted on reset or on the cycle after it.
//   - If pin_in==RESET_LEVEL throughout, no pulse occurs after reset.
// CONFIGURATION
//   LONG_PRESS_EN defined:
//     - A hold counter clears on every press and increments each cycle while level is active,
//       saturating at LONG_CYCLES.
//     - long_press pulses for 1 cycle when the count reaches LONG_CYCLES-1: at most once per press.
//     - The counter clears when level goes inactive and on rst.
//   LONG_PRESS_EN undefined:
//     - No hold counter is built. long_press is tied to 0.
//     - The port list is unchanged.
// TESTING (bench params: DEBOUNCE_CYCLES=4, CNT_W=3, LONG_CYCLES=10, ACTIVE_LOW=0, RESET_LEVEL=0)
//   1. rst, then pin_in 0->1 held -> level=1 and rise_pulse=1 for 1 cycle on the 7th posedge; press_count=1.
//   2. pin_in high for 3 cycles then low -> level stays 0, no pulses, press_count unchanged.
//   3. Bounce 1,0,1,0,1 at 1 cycle each, then held 1 -> single rise_pulse DEBOUNCE_CYCLES+3 edges after the last bounce.
//   4. 8 clean presses from count 0 -> press_count 1..7 then 0 (wrap). count_clr together with the 9th press -> press_count=1.
//   5. rst asserted 2 cycles into SETTLING -> level=0, no pulse; pin held 1 after rst -> normal rise at the 7th post-reset edge.
//   6. LONG_PRESS_EN: hold 1 for 20 cycles after rise -> exactly one long_press, 9 cycles after rise_pulse. Without the macro, long_press stays 0.

Source files
------------

// File: rtl/pin_debounce.sv
// pin_debounce: sync, debounce and edge/press detection for one raw board pin.
// Ports: clk, rst (sync, active-high), pin_in (raw async), count_clr ->
//   level (debounced), rise_pulse, fall_pulse, press_count[CNT_W], long_press.
// Build option: define LONG_PRESS_EN to build the hold counter behind
//   long_press; without it long_press is tied to 0 and the ports are unchanged.
module pin_debounce #(
  parameter int DEBOUNCE_CYCLES = 16630,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter bit RESET_LEVEL     = 1'b0,
  parameter int CNT_W           = 8,
  parameter int LONG_CYCLES     = 16630000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pin_in,
  input  logic             count_clr,
  output logic             level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] press_count,
  output logic             long_press
);

  localparam int TW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic ACT_LVL = ~ACTIVE_LOW;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   timer_d;
  logic            sync0_q;
  logic            sync1_q;
  logic            level_q;
  logic            level_d;
  logic            rise_q;
  logic            fall_q;
  logic            accept;
  logic            press_evt;
  logic [CNT_W-1:0] cnt_q;

  // Two-flop synchroniser; only sync1_q is seen by the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q <= RESET_LEVEL;
      sync1_q <= RESET_LEVEL;
    end else begin
      sync0_q <= pin_in;
      sync1_q <= sync0_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STABLE;
      timer_q <= '0;
      level_q <= RESET_LEVEL;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      level_q <= level_d;
    end
  end

  // A differing sample starts a settle window; any sample that
  // returns to the current level aborts it, so each bounce
  // restarts the window from zero.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    level_d = level_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (sync1_q != level_q) begin
          state_d = ST_SETTLING;
          timer_d = '0;
        end
      end
      ST_SETTLING: begin
        if (sync1_q == level_q) begin
          state_d = ST_STABLE;
        end else if (timer_q == T_LAST) begin
          accept  = 1'b1;
          level_d = sync1_q;
          state_d = ST_STABLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_STABLE;
      end
    endcase
  end

  assign press_evt = accept & (sync1_q == ACT_LVL);

  // Pulses are registered alongside level so they line up
  // with the cycle in which level changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept & sync1_q;
      fall_q <= accept & ~sync1_q;
    end
  end

  // A clear coinciding with a press still counts that press.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (count_clr) begin
      cnt_q <= press_evt ? CNT_W'(1) : '0;
    end else if (press_evt) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] H_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] H_HIT = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          lp_q;
  logic          lp_d;
  logic          held;

  // Level is active and not being released this cycle.
  assign held = (level_q == ACT_LVL) & ~accept;

  always_comb begin
    hold_d = '0;
    lp_d   = 1'b0;
    if (press_evt) begin
      hold_d = '0;
    end else if (held) begin
      hold_d = (hold_q == H_MAX) ? hold_q : hold_q + 1'b1;
    end
    // Counter only passes H_HIT once per press, so one pulse.
    if ((press_evt | held) && hold_d == H_HIT) begin
      lp_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      lp_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      lp_q   <= lp_d;
    end
  end

  assign long_press = lp_q;
`else
  // Always 0 for any legal LONG_CYCLES; keeps the parameter referenced.
  assign long_press = (LONG_CYCLES < 0);
`endif

  assign level       = level_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign press_count = cnt_q;

endmodule

// File: tb/tb_pin_debounce.sv
// tb_pin_debounce: directed bench for pin_debounce.
// DEBOUNCE_CYCLES=4, CNT_W=3, LONG_CYCLES=10, active-high, reset level 0.
module tb_pin_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       pin_in;
  logic       count_clr;
  logic       level;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [2:0] press_count;
  logic       long_press;

  int total = 0;
  int bad   = 0;
  int nr    = 0;
  int nf    = 0;
  int nl    = 0;
  int nboth = 0;
  int exp_lp_n;

  pin_debounce #(
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b0),
    .RESET_LEVEL(1'b0),
    .CNT_W(3),
    .LONG_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pin_in(pin_in),
    .count_clr(count_clr),
    .level(level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .press_count(press_count),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  // One posedge, then sample on the following negedge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rise_pulse) nr++;
      if (fall_pulse) nf++;
      if (long_press) nl++;
      if (rise_pulse && fall_pulse) nboth++;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_once(input logic [2:0] exp_cnt);
    pin_in = 1'b1;
    cyc(6);
    chk("press_pre_level", {31'd0, level}, 32'd0);
    cyc(1);
    chk("press_rise", {31'd0, rise_pulse}, 32'd1);
    chk("press_cnt", {29'd0, press_count}, {29'd0, exp_cnt});
    pin_in = 1'b0;
    cyc(7);
    chk("press_fall", {31'd0, fall_pulse}, 32'd1);
  endtask

  initial begin
`ifdef LONG_PRESS_EN
    exp_lp_n = 1;
`else
    exp_lp_n = 0;
`endif
    rst       = 1'b1;
    pin_in    = 1'b0;
    count_clr = 1'b0;
    @(negedge clk);
    cyc(3);
    rst = 1'b0;
    chk("rst_level", {31'd0, level}, 32'd0);
    chk("rst_rise", {31'd0, rise_pulse}, 32'd0);
    chk("rst_fall", {31'd0, fall_pulse}, 32'd0);
    chk("rst_cnt", {29'd0, press_count}, 32'd0);
    chk("rst_lp", {31'd0, long_press}, 32'd0);
    nr = 0; nf = 0; nl = 0;
    cyc(3);
    chk("idle_no_pulse", nr + nf + nl, 32'd0);

    // 1: clean rise lands on the 7th posedge; also the long hold
    pin_in = 1'b1;
    cyc(6);
    chk("t1_level_pre", {31'd0, level}, 32'd0);
    chk("t1_rise_pre", {31'd0, rise_pulse}, 32'd0);
    cyc(1);
    chk("t1_level", {31'd0, level}, 32'd1);
    chk("t1_rise", {31'd0, rise_pulse}, 32'd1);
    chk("t1_cnt", {29'd0, press_count}, 32'd1);
    cyc(1);
    chk("t1_rise_1cyc", {31'd0, rise_pulse}, 32'd0);
    chk("t1_level_hold", {31'd0, level}, 32'd1);
    // 6: long_press 9 cycles after rise_pulse
    cyc(7);
    chk("t6_lp_early", nl, 32'd0);
    cyc(1);
    chk("t6_lp", {31'd0, long_press}, exp_lp_n[31:0]);
    cyc(11);
    chk("t6_lp_once", nl, exp_lp_n[31:0]);
    pin_in = 1'b0;
    cyc(6);
    chk("t1_fall_pre", {31'd0, level}, 32'd1);
    cyc(1);
    chk("t1_fall", {31'd0, fall_pulse}, 32'd1);
    chk("t1_level_low", {31'd0, level}, 32'd0);
    chk("t1_cnt_fall", {29'd0, press_count}, 32'd1);

    // 2: 3-cycle glitch is rejected
    nr = 0; nf = 0;
    cyc(1);
    pin_in = 1'b1;
    cyc(3);
    pin_in = 1'b0;
    cyc(10);
    chk("t2_level", {31'd0, level}, 32'd0);
    chk("t2_pulses", nr + nf, 32'd0);
    chk("t2_cnt", {29'd0, press_count}, 32'd1);

    // 3: bounce 1,0,1,0 then held 1
    nr = 0;
    pin_in = 1'b1; cyc(1);
    pin_in = 1'b0; cyc(1);
    pin_in = 1'b1; cyc(1);
    pin_in = 1'b0; cyc(1);
    pin_in = 1'b1;
    cyc(6);
    chk("t3_pre_rise", nr, 32'd0);
    chk("t3_pre_level", {31'd0, level}, 32'd0);
    cyc(1);
    chk("t3_rise", {31'd0, rise_pulse}, 32'd1);
    chk("t3_cnt", {29'd0, press_count}, 32'd2);
    cyc(4);
    chk("t3_single", nr, 32'd1);
    pin_in = 1'b0;
    cyc(8);
    chk("t3_released", {31'd0, level}, 32'd0);

    // 4: clear, 8 presses with wrap, clear with 9th press
    count_clr = 1'b1;
    cyc(1);
    count_clr = 1'b0;
    chk("t4_clr", {29'd0, press_count}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      logic [2:0] e;
      e = 3'(i);
      press_once(e);
    end
    chk("t4_wrap", {29'd0, press_count}, 32'd0);
    pin_in = 1'b1;
    cyc(4);
    count_clr = 1'b1;
    cyc(1);
    count_clr = 1'b0;
    chk("t4_clr_only", {29'd0, press_count}, 32'd0);
    cyc(1);
    count_clr = 1'b1;
    cyc(1);
    count_clr = 1'b0;
    chk("t4_clr_press_rise", {31'd0, rise_pulse}, 32'd1);
    chk("t4_clr_press", {29'd0, press_count}, 32'd1);
    pin_in = 1'b0;
    cyc(8);

    // 5: reset two cycles into SETTLING
    nr = 0; nf = 0;
    pin_in = 1'b1;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t5_rst_level", {31'd0, level}, 32'd0);
    chk("t5_rst_cnt", {29'd0, press_count}, 32'd0);
    chk("t5_rst_pulse", nr + nf, 32'd0);
    cyc(6);
    chk("t5_pre_level", {31'd0, level}, 32'd0);
    chk("t5_pre_rise", nr, 32'd0);
    cyc(1);
    chk("t5_rise", {31'd0, rise_pulse}, 32'd1);
    chk("t5_level", {31'd0, level}, 32'd1);
    chk("t5_cnt", {29'd0, press_count}, 32'd1);
    pin_in = 1'b0;
    cyc(8);
    chk("t5_end_level", {31'd0, level}, 32'd0);

    chk("never_both", nboth, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
